// File: rtl/converter_scan_bcd.sv
// converter_scan_bcd: binary to BCD (double dabble) converter
// with a multiplexed, active-low 7-segment scan driver.
//
// Ports:
//   clk_pin      sole clock, rising edge
//   reset_pin    synchronous active-high reset
//   binary_input value to convert (two's complement if SIGNED)
//   load         conversion request strobe (honoured in IDLE only)
//   blank_en     leading-zero blanking enable
//   busy         conversion in progress (SHIFT or COMMIT)
//   done         one-cycle pulse while the result is committed
//   overflow     committed value does not fit the display
//   dispC        {CA..CG,DP} segment drive, active-low, registered
//   dispAN       {AN0..AN7} anode drive, active-low, registered
module converter_scan_bcd #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 10000,
    parameter bit SIGNED   = 1'b0
) (
    input  logic             clk_pin,
    input  logic             reset_pin,
    input  logic [WIDTH-1:0] binary_input,
    input  logic             load,
    input  logic             blank_en,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [7:0]       dispC,
    output logic [7:0]       dispAN
);

    // BCD accumulator is wide enough that no step loses a bit
    localparam int NB = (WIDTH + 2) / 3 + 1;
    localparam int BW = 4 * NB;
    localparam int CW = $clog2(WIDTH);
    localparam int SW = $clog2(SCAN_DIV);

    localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [2:0]    DIG_LAST  = 3'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             start;
    logic             step;
    logic             commit;

    logic [WIDTH-1:0] bin_q;
    logic [BW-1:0]    bcd_q;
    logic [BW-1:0]    bcd_adj;
    logic             neg_q;
    logic [CW-1:0]    bit_cnt;

    logic             in_neg;
    logic [WIDTH-1:0] in_mag;
    logic             ovf_d;

    logic [BW-1:0]    disp_bcd;
    logic             disp_neg;

    logic [SW-1:0]    scan_cnt;
    logic [2:0]       dig_q;
    logic [3:0]       cur_nib;
    logic             upper_nz;
    logic             blank;
    logic [7:0]       seg_d;
    logic [7:0]       an_d;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 8'h03;
            4'd1:    seg7 = 8'h9F;
            4'd2:    seg7 = 8'h25;
            4'd3:    seg7 = 8'h0D;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h49;
            4'd6:    seg7 = 8'h41;
            4'd7:    seg7 = 8'h1F;
            4'd8:    seg7 = 8'h01;
            4'd9:    seg7 = 8'h09;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_pin) begin
        if (reset_pin) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == COMMIT);
        start  = (state_q == IDLE) && load;
        step   = (state_q == SHIFT);
        commit = (state_q == COMMIT);
    end

    // Magnitude of the input; the most negative value wraps to
    // 2^(WIDTH-1), which is still correct read as unsigned.
    always_comb begin
        in_neg = SIGNED && binary_input[WIDTH-1];
        in_mag = binary_input;
        if (in_neg) begin
            in_mag = ~binary_input + WIDTH'(1);
        end
    end

    // Add 3 to every nibble >= 5 before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NB; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // ---------------- conversion datapath ----------------
    always_ff @(posedge clk_pin) begin
        if (reset_pin) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            bit_cnt <= '0;
        end else if (start) begin
            bin_q   <= in_mag;
            bcd_q   <= '0;
            neg_q   <= in_neg;
            bit_cnt <= '0;
        end else if (step) begin
            bin_q   <= {bin_q[WIDTH-2:0], 1'b0};
            bcd_q   <= BW'({bcd_adj, bin_q[WIDTH-1]});
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    // A negative value gives up the top digit to the minus sign
    always_comb begin
        int avail;
        avail = neg_q ? DIGITS - 1 : DIGITS;
        ovf_d = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i >= avail && bcd_q[4*i +: 4] != 4'd0) begin
                ovf_d = 1'b1;
            end
        end
    end

    // ---------------- display register ----------------
    always_ff @(posedge clk_pin) begin
        if (reset_pin) begin
            disp_bcd <= '0;
            disp_neg <= 1'b0;
            overflow <= 1'b0;
        end else if (commit) begin
            disp_bcd <= bcd_q;
            disp_neg <= neg_q;
            overflow <= ovf_d;
        end
    end

    // ---------------- scan: digit select ----------------
    always_comb begin
        cur_nib  = 4'd0;
        upper_nz = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i == int'(dig_q)) begin
                cur_nib = disp_bcd[4*i +: 4];
            end
            if (i > int'(dig_q) && disp_bcd[4*i +: 4] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end
    end

    // Digit 0 is never blanked so zero still reads "0"
    assign blank = blank_en && (dig_q != 3'd0)
                 && (cur_nib == 4'd0) && !upper_nz;

    always_comb begin
        seg_d = seg7(cur_nib);
        if (overflow) begin
            seg_d = 8'hFD;
        end else if (disp_neg && dig_q == DIG_LAST) begin
            seg_d = 8'hFD;
        end else if (blank) begin
            seg_d = 8'hFF;
        end
    end

    always_comb begin
        an_d = 8'hFF;
        an_d[3'd7 - dig_q] = 1'b0;
    end

    // ---------------- scan: counters and output regs ----------------
    always_ff @(posedge clk_pin) begin
        if (reset_pin) begin
            scan_cnt <= '0;
            dig_q    <= 3'd0;
            dispC    <= 8'hFF;
            dispAN   <= 8'hFF;
        end else begin
            dispC  <= seg_d;
            dispAN <= an_d;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                if (dig_q == DIG_LAST) begin
                    dig_q <= 3'd0;
                end else begin
                    dig_q <= dig_q + 3'd1;
                end
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_converter_scan_bcd.sv
// tb_converter_scan_bcd: randomized self-checking bench for
// converter_scan_bcd, four parameter sets sharing one stimulus.
module tb_converter_scan_bcd;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_pin;
    logic         load;
    logic         blank_en;
    logic [W-1:0] bin;

    logic         bsy [4];
    logic         dn  [4];
    logic         ov  [4];
    logic [7:0]   dc  [4];
    logic [7:0]   da  [4];

    int nd [4] = '{8, 4, 8, 3};
    int sd [4] = '{4, 3, 2, 4};
    bit sg [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    int total = 0;
    int bad   = 0;

    logic [7:0] cap    [4][8];
    bit         seen   [4][8];
    int         an_err [4];
    int         lat    [4];
    int         ndn    [4];
    int         nbsy   [4];

    always #5 clk = ~clk;

    converter_scan_bcd #(.WIDTH(W), .DIGITS(8), .SCAN_DIV(4),
                         .SIGNED(1'b0)) dut_a (
        .clk_pin(clk), .reset_pin(reset_pin),
        .binary_input(bin), .load(load), .blank_en(blank_en),
        .busy(bsy[0]), .done(dn[0]), .overflow(ov[0]),
        .dispC(dc[0]), .dispAN(da[0]));

    converter_scan_bcd #(.WIDTH(W), .DIGITS(4), .SCAN_DIV(3),
                         .SIGNED(1'b0)) dut_b (
        .clk_pin(clk), .reset_pin(reset_pin),
        .binary_input(bin), .load(load), .blank_en(blank_en),
        .busy(bsy[1]), .done(dn[1]), .overflow(ov[1]),
        .dispC(dc[1]), .dispAN(da[1]));

    converter_scan_bcd #(.WIDTH(W), .DIGITS(8), .SCAN_DIV(2),
                         .SIGNED(1'b1)) dut_c (
        .clk_pin(clk), .reset_pin(reset_pin),
        .binary_input(bin), .load(load), .blank_en(blank_en),
        .busy(bsy[2]), .done(dn[2]), .overflow(ov[2]),
        .dispC(dc[2]), .dispAN(da[2]));

    converter_scan_bcd #(.WIDTH(W), .DIGITS(3), .SCAN_DIV(4),
                         .SIGNED(1'b0)) dut_d (
        .clk_pin(clk), .reset_pin(reset_pin),
        .binary_input(bin), .load(load), .blank_en(blank_en),
        .busy(bsy[3]), .done(dn[3]), .overflow(ov[3]),
        .dispC(dc[3]), .dispAN(da[3]));

    // ---------------- reference model ----------------
    function automatic bit neg_of(logic [W-1:0] x, bit s);
        return s && x[W-1];
    endfunction

    function automatic longint mag_of(logic [W-1:0] x, bit s);
        if (s && x[W-1]) return (longint'(1) << W) - longint'(x);
        return longint'(x);
    endfunction

    function automatic longint pow10(int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic bit ovf_model(longint mag, bit neg, int ndig);
        return mag >= pow10(neg ? ndig - 1 : ndig);
    endfunction

    function automatic logic [7:0] seg_of(longint d);
        case (d)
            0: return 8'h03;
            1: return 8'h9F;
            2: return 8'h25;
            3: return 8'h0D;
            4: return 8'h99;
            5: return 8'h49;
            6: return 8'h41;
            7: return 8'h1F;
            8: return 8'h01;
            9: return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] digit_model(longint mag, bit neg,
                                               int ndig, bit blk, int k);
        if (ovf_model(mag, neg, ndig)) return 8'hFD;
        if (neg && k == ndig - 1) return 8'hFD;
        if (blk && k > 0 && mag < pow10(k)) return 8'hFF;
        return seg_of((mag / pow10(k)) % 10);
    endfunction

    // ---------------- stimulus / observation ----------------
    task automatic capture(input int cycles);
        logic [7:0] low;
        for (int j = 0; j < 4; j++) begin
            an_err[j] = 0;
            for (int k = 0; k < 8; k++) begin
                seen[j][k] = 1'b0;
                cap[j][k]  = 8'h00;
            end
        end
        repeat (cycles) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                low = 8'hFF >> nd[j];
                if ($countones(~da[j]) > 1 || (da[j] & low) != low)
                    an_err[j]++;
                for (int k = 0; k < nd[j]; k++) begin
                    if (da[j] == ~(8'h80 >> k)) begin
                        cap[j][k]  = dc[j];
                        seen[j][k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic convert(input logic [W-1:0] v);
        @(negedge clk);
        bin  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int j = 0; j < 4; j++) begin
            lat[j] = -1; ndn[j] = 0; nbsy[j] = 0;
        end
        for (int n = 1; n <= 40; n++) begin
            for (int j = 0; j < 4; j++) begin
                if (dn[j] === 1'b1) begin
                    ndn[j]++;
                    if (lat[j] < 0) lat[j] = n;
                end
                if (bsy[j] === 1'b1) nbsy[j]++;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_display(input logic [W-1:0] v, input string tag);
        longint m;
        bit     ng;
        logic [7:0] e;
        capture(40);
        for (int j = 0; j < 4; j++) begin
            m  = mag_of(v, sg[j]);
            ng = neg_of(v, sg[j]);
            total++;
            if (ov[j] !== ovf_model(m, ng, nd[j])) begin
                bad++;
                $display("FAIL %s ovf dut%0d v=%h got=%b want=%b",
                         tag, j, v, ov[j], ovf_model(m, ng, nd[j]));
            end
            total++;
            if (an_err[j] != 0) begin
                bad++;
                $display("FAIL %s anode dut%0d bad_samples=%0d want=0",
                         tag, j, an_err[j]);
            end
            for (int k = 0; k < nd[j]; k++) begin
                e = digit_model(m, ng, nd[j], blank_en, k);
                total++;
                if (!seen[j][k] || cap[j][k] !== e) begin
                    bad++;
                    $display("FAIL %s digit dut%0d v=%h k=%0d got=%h want=%h",
                             tag, j, v, k, cap[j][k], e);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_pin = 1'b1;
        load      = 1'b0;
        blank_en  = 1'b1;
        bin       = '0;
        repeat (2) @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            total++;
            if (bsy[j] !== 1'b0 || dn[j] !== 1'b0 || ov[j] !== 1'b0) begin
                bad++;
                $display("FAIL reset_flags dut%0d got=%b%b%b want=000",
                         j, bsy[j], dn[j], ov[j]);
            end
            total++;
            if (dc[j] !== 8'hFF || da[j] !== 8'hFF) begin
                bad++;
                $display("FAIL reset_disp dut%0d got=%h/%h want=FF/FF",
                         j, dc[j], da[j]);
            end
        end
        reset_pin = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            total++;
            if (dc[j] !== 8'h03 || da[j] !== 8'h7F) begin
                bad++;
                $display("FAIL first_scan dut%0d got=%h/%h want=03/7F",
                         j, dc[j], da[j]);
            end
        end
    endtask

    task automatic test_latency();
        logic [7:0] want [8];
        want = '{8'h99, 8'h0D, 8'h25, 8'h9F,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        blank_en = 1'b1;
        convert(16'd1234);
        for (int j = 0; j < 4; j++) begin
            total++;
            if (lat[j] != W + 1 || ndn[j] != 1) begin
                bad++;
                $display("FAIL latency dut%0d got=%0d/%0d want=%0d/1",
                         j, lat[j], ndn[j], W + 1);
            end
            total++;
            if (nbsy[j] != W + 1) begin
                bad++;
                $display("FAIL busy_len dut%0d got=%0d want=%0d",
                         j, nbsy[j], W + 1);
            end
        end
        capture(40);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (cap[0][k] !== want[k]) begin
                bad++;
                $display("FAIL d1234 k=%0d got=%h want=%h",
                         k, cap[0][k], want[k]);
            end
        end
    endtask

    task automatic test_patterns();
        logic [W-1:0] vals [10];
        logic [W-1:0] v;
        vals = '{16'd1234, 16'hFFFF, 16'd12345, 16'h8000, 16'd0,
                 16'd100, 16'd9999, 16'd10000, 16'd999, 16'h7FFF};
        for (int i = 0; i < 10; i++) begin
            blank_en = (i % 3 != 1);
            convert(vals[i]);
            check_display(vals[i], "pattern");
        end
        for (int i = 0; i < 6; i++) begin
            v = W'($urandom());
            blank_en = 1'($urandom_range(0, 1));
            convert(v);
            check_display(v, "random");
        end
    endtask

    task automatic test_back_to_back();
        int cnt [4];
        blank_en = 1'b1;
        @(negedge clk);
        bin  = 16'd100;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int j = 0; j < 4; j++) cnt[j] = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 3) begin
                bin  = 16'd7;
                load = 1'b1;
                total++;
                if (bsy[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_busy got=%b want=1", bsy[0]);
                end
            end else begin
                load = 1'b0;
            end
            for (int j = 0; j < 4; j++)
                if (dn[j] === 1'b1) cnt[j]++;
            @(negedge clk);
        end
        load = 1'b0;
        for (int j = 0; j < 4; j++) begin
            total++;
            if (cnt[j] != 1) begin
                bad++;
                $display("FAIL b2b_done dut%0d got=%0d want=1", j, cnt[j]);
            end
        end
        check_display(16'd100, "b2b");
    endtask

    task automatic test_reset_abort();
        int cnt;
        blank_en = 1'b1;
        @(negedge clk);
        bin  = 16'd4321;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        reset_pin = 1'b1;
        @(negedge clk);
        reset_pin = 1'b0;
        for (int j = 0; j < 4; j++) begin
            total++;
            if (bsy[j] !== 1'b0 || dn[j] !== 1'b0 ||
                dc[j] !== 8'hFF || da[j] !== 8'hFF) begin
                bad++;
                $display("FAIL abort dut%0d got=%b%b %h/%h want=00 FF/FF",
                         j, bsy[j], dn[j], dc[j], da[j]);
            end
        end
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++)
                if (dn[j] === 1'b1) cnt++;
        end
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL abort_done got=%0d want=0", cnt);
        end
        reset_pin = 1'b1;
        load      = 1'b1;
        bin       = 16'd555;
        @(negedge clk);
        reset_pin = 1'b0;
        load      = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            total++;
            if (bsy[j] !== 1'b0) begin
                bad++;
                $display("FAIL load_in_reset dut%0d got=%b want=0",
                         j, bsy[j]);
            end
        end
        check_display(16'd0, "post_reset");
    endtask

    task automatic test_scan();
        logic [7:0] e;
        @(negedge clk);
        reset_pin = 1'b1;
        @(negedge clk);
        reset_pin = 1'b0;
        for (int m = 1; m <= 30; m++) begin
            if (m == 6) begin
                bin  = 16'd55;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                e = ~(8'h80 >> (((m - 1) / sd[j]) % nd[j]));
                total++;
                if (da[j] !== e) begin
                    bad++;
                    $display("FAIL scan dut%0d m=%0d got=%h want=%h",
                             j, m, da[j], e);
                end
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_patterns();
        test_back_to_back();
        test_reset_abort();
        test_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
